// File: rtl/matrix_result_regfile.sv
// matrix_result_regfile: a bank of NUM_REGS result elements written over a
// valid/ready port, with overwrite or accumulate writes and fill tracking.
// Optional macro MATRIX_RF_SATURATE_EN: accumulate clamps to all-ones on carry.
// Ports:
//   clk, reset (async, active-high), clear (sync)
//   wr_valid/wr_ready/wr_addr/wr_data/acc_mode: write port
//   rd_addr -> rd_data (registered read, 0 when out of range)
//   contents (flat bus of all elements), written (per-register fill bits)
//   done (all registers written), addr_err (pulse), ovf (sticky carry flag)
module matrix_result_regfile #(
    parameter int ELEM_W   = 6,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [ELEM_W-1:0]          wr_data,
    input  logic                       acc_mode,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [ELEM_W-1:0]          rd_data,
    output logic [NUM_REGS*ELEM_W-1:0] contents,
    output logic [NUM_REGS-1:0]        written,
    output logic                       done,
    output logic                       addr_err,
    output logic                       ovf
);

    localparam logic [1:0] S_EMPTY    = 2'd0;
    localparam logic [1:0] S_FILLING  = 2'd1;
    localparam logic [1:0] S_COMPLETE = 2'd2;

    logic [1:0]                 r_state;
    logic [NUM_REGS*ELEM_W-1:0] r_contents;
    logic [NUM_REGS-1:0]        r_written;
    logic [ELEM_W-1:0]          r_rd_data;
    logic                       r_ovf;
    logic                       r_addr_err;

    logic                w_ready;
    logic                w_accept;
    logic                w_wr_in_range;
    logic                w_do_write;
    logic                w_carry;
    logic [ELEM_W-1:0]   w_old;
    logic [ELEM_W-1:0]   w_rd_sel;
    logic [ELEM_W-1:0]   w_new;
    logic [ELEM_W:0]     w_sum;
    logic [NUM_REGS-1:0] w_wr_onehot;
    logic [NUM_REGS-1:0] w_written_next;

    // Address decode: an address is in range exactly when it matches one
    // of the NUM_REGS slots, so the one-hot doubles as the range check.
    always_comb begin
        w_old       = '0;
        w_rd_sel    = '0;
        w_wr_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_addr == ADDR_W'(i)) begin
                w_old          = r_contents[i*ELEM_W +: ELEM_W];
                w_wr_onehot[i] = 1'b1;
            end
            if (rd_addr == ADDR_W'(i)) begin
                w_rd_sel = r_contents[i*ELEM_W +: ELEM_W];
            end
        end
    end

    assign w_ready        = (r_state != S_COMPLETE);
    assign w_accept       = wr_valid & w_ready;
    assign w_wr_in_range  = |w_wr_onehot;
    assign w_do_write     = w_accept & w_wr_in_range;
    assign w_written_next = r_written | w_wr_onehot;

    assign w_sum   = {1'b0, w_old} + {1'b0, wr_data};
    assign w_carry = w_sum[ELEM_W];

`ifdef MATRIX_RF_SATURATE_EN
    assign w_new = !acc_mode ? wr_data :
                   w_carry   ? {ELEM_W{1'b1}} : w_sum[ELEM_W-1:0];
`else
    assign w_new = acc_mode ? w_sum[ELEM_W-1:0] : wr_data;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_EMPTY;
            r_contents <= '0;
            r_written  <= '0;
            r_rd_data  <= '0;
            r_ovf      <= 1'b0;
            r_addr_err <= 1'b0;
        end else if (clear) begin
            r_state    <= S_EMPTY;
            r_contents <= '0;
            r_written  <= '0;
            r_rd_data  <= '0;
            r_ovf      <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            // Read samples pre-write contents, giving old data on collision.
            r_rd_data  <= w_rd_sel;
            r_addr_err <= w_accept & ~w_wr_in_range;
            if (w_do_write) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (w_wr_onehot[i]) begin
                        r_contents[i*ELEM_W +: ELEM_W] <= w_new;
                    end
                end
                r_written <= w_written_next;
                if (acc_mode && w_carry) begin
                    r_ovf <= 1'b1;
                end
                // Any accepted write lands in FILLING or COMPLETE; a rewrite
                // of an already-set bit leaves FILLING unchanged.
                if (&w_written_next) begin
                    r_state <= S_COMPLETE;
                end else begin
                    r_state <= S_FILLING;
                end
            end
        end
    end

    assign wr_ready = w_ready;
    assign done     = (r_state == S_COMPLETE);
    assign rd_data  = r_rd_data;
    assign contents = r_contents;
    assign written  = r_written;
    assign addr_err = r_addr_err;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_matrix_result_regfile.sv
// tb_matrix_result_regfile: directed self-checking bench for the default
// 8-register build and a 6-register build (out-of-range handling).
module tb_matrix_result_regfile;

    logic clk = 1'b0;
    logic reset;
    logic clear;
    always #5 clk = ~clk;

    logic        a_wr_valid, a_wr_ready, a_acc, a_done, a_err, a_ovf;
    logic [2:0]  a_wr_addr, a_rd_addr;
    logic [5:0]  a_wr_data, a_rd_data;
    logic [47:0] a_contents;
    logic [7:0]  a_written;

    logic        b_wr_valid, b_wr_ready, b_acc, b_done, b_err, b_ovf;
    logic [2:0]  b_wr_addr, b_rd_addr;
    logic [5:0]  b_wr_data, b_rd_data;
    logic [35:0] b_contents;
    logic [5:0]  b_written;

    matrix_result_regfile #(.ELEM_W(6), .NUM_REGS(8), .ADDR_W(3)) u_a (
        .clk(clk), .reset(reset), .clear(clear),
        .wr_valid(a_wr_valid), .wr_ready(a_wr_ready),
        .wr_addr(a_wr_addr), .wr_data(a_wr_data), .acc_mode(a_acc),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .contents(a_contents), .written(a_written),
        .done(a_done), .addr_err(a_err), .ovf(a_ovf)
    );

    matrix_result_regfile #(.ELEM_W(6), .NUM_REGS(6), .ADDR_W(3)) u_b (
        .clk(clk), .reset(reset), .clear(clear),
        .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
        .wr_addr(b_wr_addr), .wr_data(b_wr_data), .acc_mode(b_acc),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .contents(b_contents), .written(b_written),
        .done(b_done), .addr_err(b_err), .ovf(b_ovf)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [47:0] exp_full;
    logic [5:0]  exp_acc;

    initial begin
        reset = 1'b1; clear = 1'b0;
        a_wr_valid = 0; a_wr_addr = 0; a_wr_data = 0; a_acc = 0; a_rd_addr = 0;
        b_wr_valid = 0; b_wr_addr = 0; b_wr_data = 0; b_acc = 0; b_rd_addr = 0;
        #1;
        check("rst_contents", a_contents, 0);
        check("rst_rd_data", a_rd_data, 0);
        check("rst_written", a_written, 0);
        check("rst_done", a_done, 0);
        check("rst_ready", a_wr_ready, 1);
        check("rst_ovf", a_ovf, 0);
        check("rst_err", a_err, 0);
        step();
        reset = 1'b0;
        step();

        // 6-register build: out-of-range write and read
        b_wr_valid = 1; b_wr_addr = 3'd6; b_wr_data = 6'h11; b_rd_addr = 3'd7;
        step();
        b_wr_valid = 0;
        check("b_err_pulse", b_err, 1);
        check("b_written", b_written, 0);
        check("b_contents", b_contents, 0);
        check("b_ready", b_wr_ready, 1);
        check("b_done", b_done, 0);
        check("b_rd_oor", b_rd_data, 0);
        step();
        check("b_err_clr", b_err, 0);
        b_wr_valid = 1; b_wr_addr = 3'd5; b_wr_data = 6'h2A; b_rd_addr = 3'd5;
        step();
        b_wr_valid = 0;
        check("b_written5", b_written, 6'b100000);
        step();
        check("b_rd5", b_rd_data, 6'h2A);

        // fill all 8 registers with 1..8
        for (int i = 0; i < 8; i++) begin
            a_wr_valid = 1; a_wr_addr = 3'(i); a_wr_data = 6'(i + 1);
            step();
            if (i == 0) begin
                check("fill_first_written", a_written, 8'h01);
                check("fill_first_done", a_done, 0);
            end
        end
        a_wr_valid = 0;
        for (int i = 0; i < 8; i++) exp_full[i*6 +: 6] = 6'(i + 1);
        check("fill_contents", a_contents, exp_full);
        check("fill_written", a_written, 8'hFF);
        check("fill_done", a_done, 1);
        check("fill_ready", a_wr_ready, 0);

        // writes are refused while complete
        a_wr_valid = 1; a_wr_addr = 0; a_wr_data = 6'h3F; a_rd_addr = 3'd2;
        step();
        a_wr_valid = 0;
        check("complete_block", a_contents, exp_full);
        check("complete_rd2", a_rd_data, 6'h03);

        // clear beats a simultaneous write
        clear = 1; a_wr_valid = 1; a_wr_addr = 3'd2; a_wr_data = 6'h2A;
        step();
        clear = 0; a_wr_valid = 0;
        check("clr_contents", a_contents, 0);
        check("clr_written", a_written, 0);
        check("clr_ready", a_wr_ready, 1);
        check("clr_done", a_done, 0);

        // accumulate overflow
        a_wr_valid = 1; a_wr_addr = 3'd3; a_wr_data = 6'h3C; a_acc = 0;
        step();
        a_wr_data = 6'h08; a_acc = 1;
        step();
        a_wr_valid = 0; a_acc = 0;
`ifdef MATRIX_RF_SATURATE_EN
        exp_acc = 6'h3F;
`else
        exp_acc = 6'h04;
`endif
        check("acc_reg3", a_contents[18 +: 6], exp_acc);
        check("acc_ovf", a_ovf, 1);
        check("acc_written", a_written, 8'h08);
        check("acc_done", a_done, 0);
        a_wr_valid = 1; a_wr_addr = 3'd4; a_wr_data = 6'h01;
        step();
        a_wr_valid = 0;
        check("ovf_sticky", a_ovf, 1);
        check("ovr_reg4", a_contents[24 +: 6], 6'h01);

        // read/write collision on reg 5
        a_wr_valid = 1; a_wr_addr = 3'd5; a_wr_data = 6'h11;
        step();
        a_wr_data = 6'h22; a_rd_addr = 3'd5;
        step();
        a_wr_valid = 0;
        check("rw_old", a_rd_data, 6'h11);
        step();
        check("rw_new", a_rd_data, 6'h22);
        check("rw_reg5", a_contents[30 +: 6], 6'h22);

        // asynchronous reset between edges while filling, write in flight
        a_wr_valid = 1; a_wr_addr = 3'd6; a_wr_data = 6'h15;
        #2 reset = 1;
        #1;
        check("async_contents", a_contents, 0);
        check("async_rd", a_rd_data, 0);
        check("async_written", a_written, 0);
        check("async_done", a_done, 0);
        check("async_ready", a_wr_ready, 1);
        check("async_ovf", a_ovf, 0);
        step();
        a_wr_valid = 0;
        reset = 0;
        step();
        check("post_rst_contents", a_contents, 0);
        check("post_rst_written", a_written, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
